// File: rtl/relogio_pkg.sv
// Shared types and constants for the adjustable clock: FSM states, the BCD
// seven-segment table, the display record and the per-digit limits.
package relogio_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] msd;
        logic [3:0] lsd;
    } bcd2_t;

    typedef struct packed {
        logic [6:0] h_msd;
        logic [6:0] h_lsd;
        logic [6:0] m_msd;
        logic [6:0] m_lsd;
        logic [6:0] s_msd;
        logic [6:0] s_lsd;
        logic       pm;
    } disp_t;

    // Active-high codes, bit0 = a ... bit6 = g; index 15 is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [3:0] LIM_MIN_MSD  = 4'd5;
    localparam logic [3:0] LIM_DEC_LSD  = 4'd9;
    localparam logic [3:0] LIM_HOUR_MSD = 4'd2;
    localparam logic [3:0] LIM_HOUR_LSD = 4'd3;

    function automatic logic [6:0] seg_encode(
        input logic [3:0] digit,
        input logic       blank,
        input logic       active_low
    );
        logic [6:0] code;
        code = blank ? SEG_BLANK : SEG_TABLE[digit];
        return active_low ? ~code : code;
    endfunction

endpackage

// File: rtl/contador_mod_bcd.sv
// Two-digit BCD counter that counts 00 .. MODULUS-1 and wraps to 00; wrap_o
// flags the increment that performs the wrap so counters can be chained.
module contador_mod_bcd
    import relogio_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  inc_i,
    input  logic  clr_i,
    output bcd2_t value_o,
    output logic  wrap_o
);

    localparam logic [3:0] LAST_MSD = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] LAST_LSD = 4'((MODULUS - 1) % 10);

    bcd2_t cnt_q;
    bcd2_t cnt_d;
    logic  at_last;

    assign at_last = (cnt_q.msd == LAST_MSD) && (cnt_q.lsd == LAST_LSD);
    assign wrap_o  = inc_i && !clr_i && at_last;
    assign value_o = cnt_q;

    // Clear beats increment so a synchronous clear can never be skipped.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            if (at_last) begin
                cnt_d = '0;
            end else if (cnt_q.lsd == LIM_DEC_LSD) begin
                cnt_d.lsd = 4'd0;
                cnt_d.msd = cnt_q.msd + 4'd1;
            end else begin
                cnt_d.lsd = cnt_q.lsd + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/relogio_ajustavel.sv
// Adjustable HH:MM:SS clock with a RUN/SET_H/SET_M editor, blinking edit
// field, optional 12 h display and registered seven-segment outputs.
module relogio_ajustavel
    import relogio_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int MODE_12H       = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd,
    output logic       pm,
    output logic [1:0] mode_o,
    output logic       carry_day
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

    localparam int SEC_MOD  = int'(LIM_MIN_MSD) * 10 + int'(LIM_DEC_LSD) + 1;
    localparam int HOUR_MOD = int'(LIM_HOUR_MSD) * 10 + int'(LIM_HOUR_LSD) + 1;

    localparam logic       IS_12H = (MODE_12H != 0);
    localparam logic       ACT_LO = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] RST_ZERO  = seg_encode(4'd0, 1'b0, ACT_LO);
    localparam logic [6:0] RST_H_MSD = IS_12H ? seg_encode(4'd0, 1'b1, ACT_LO) : RST_ZERO;
    localparam logic [6:0] RST_H_LSD = IS_12H ? seg_encode(4'd2, 1'b0, ACT_LO) : RST_ZERO;
    localparam disp_t DISP_RST = '{
        h_msd: RST_H_MSD, h_lsd: RST_H_LSD,
        m_msd: RST_ZERO,  m_lsd: RST_ZERO,
        s_msd: RST_ZERO,  s_lsd: RST_ZERO,
        pm:    1'b0
    };

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          carry_q;
    logic          carry_d;
    disp_t         disp_q;
    disp_t         disp_d;

    logic  tick;
    logic  run_tick;
    logic  inc_only;
    logic  leave_set_m;
    logic  sec_inc;
    logic  min_inc;
    logic  hour_inc;
    logic  sec_wrap;
    logic  min_wrap;
    logic  hour_wrap;
    bcd2_t sec_v;
    bcd2_t min_v;
    bcd2_t hour_v;

    // Buttons are single-cycle debounced pulses with no handshake: a pulse is
    // consumed on the edge it is seen, and btn_mode wins over btn_inc.
    assign tick        = (presc_q == PRESC_LAST);
    assign run_tick    = tick && (state_q == ST_RUN);
    assign inc_only    = btn_inc && !btn_mode;
    assign leave_set_m = btn_mode && (state_q == ST_SET_M);

    assign sec_inc  = run_tick;
    assign min_inc  = (run_tick && sec_wrap) || ((state_q == ST_SET_M) && inc_only);
    assign hour_inc = (run_tick && min_wrap) || ((state_q == ST_SET_H) && inc_only);

    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Leaving SET_M restarts the second so the edited minute begins cleanly.
    always_comb begin
        if (leave_set_m || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    assign carry_d = run_tick && hour_wrap;

    contador_mod_bcd #(.MODULUS(SEC_MOD)) u_sec (
        .clk_i   (main_clock),
        .rst_i   (main_reset),
        .inc_i   (sec_inc),
        .clr_i   (leave_set_m),
        .value_o (sec_v),
        .wrap_o  (sec_wrap)
    );

    contador_mod_bcd #(.MODULUS(SEC_MOD)) u_min (
        .clk_i   (main_clock),
        .rst_i   (main_reset),
        .inc_i   (min_inc),
        .clr_i   (1'b0),
        .value_o (min_v),
        .wrap_o  (min_wrap)
    );

    contador_mod_bcd #(.MODULUS(HOUR_MOD)) u_hour (
        .clk_i   (main_clock),
        .rst_i   (main_reset),
        .inc_i   (hour_inc),
        .clr_i   (1'b0),
        .value_o (hour_v),
        .wrap_o  (hour_wrap)
    );

    logic [4:0] hour_bin;
    logic [4:0] hour12;
    logic [3:0] h_dig_msd;
    logic [3:0] h_dig_lsd;
    logic       blank_h;
    logic       blank_m;
    logic       blank_h_msd;

    // Hours stay in 24 h BCD internally; 12 h form exists only on the display.
    always_comb begin
        hour_bin = 5'(hour_v.msd) * 5'd10 + 5'(hour_v.lsd);
        if (hour_bin == 5'd0) begin
            hour12 = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour12 = hour_bin - 5'd12;
        end else begin
            hour12 = hour_bin;
        end

        if (IS_12H) begin
            h_dig_msd = (hour12 >= 5'd10) ? 4'd1 : 4'd0;
            h_dig_lsd = (hour12 >= 5'd10) ? 4'(hour12 - 5'd10) : 4'(hour12);
        end else begin
            h_dig_msd = hour_v.msd;
            h_dig_lsd = hour_v.lsd;
        end

        blank_h     = (state_q == ST_SET_H) && (presc_q < PRESC_HALF);
        blank_m     = (state_q == ST_SET_M) && (presc_q < PRESC_HALF);
        blank_h_msd = blank_h || (IS_12H && (h_dig_msd == 4'd0));

        disp_d.h_msd = seg_encode(h_dig_msd, blank_h_msd, ACT_LO);
        disp_d.h_lsd = seg_encode(h_dig_lsd, blank_h, ACT_LO);
        disp_d.m_msd = seg_encode(min_v.msd, blank_m, ACT_LO);
        disp_d.m_lsd = seg_encode(min_v.lsd, blank_m, ACT_LO);
        disp_d.s_msd = seg_encode(sec_v.msd, 1'b0, ACT_LO);
        disp_d.s_lsd = seg_encode(sec_v.lsd, 1'b0, ACT_LO);
        disp_d.pm    = IS_12H && (hour_bin >= 5'd12);
    end

    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            carry_q <= 1'b0;
            disp_q  <= DISP_RST;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            carry_q <= carry_d;
            disp_q  <= disp_d;
        end
    end

    assign h_msd     = disp_q.h_msd;
    assign h_lsd     = disp_q.h_lsd;
    assign m_msd     = disp_q.m_msd;
    assign m_lsd     = disp_q.m_lsd;
    assign s_msd     = disp_q.s_msd;
    assign s_lsd     = disp_q.s_lsd;
    assign pm        = disp_q.pm;
    assign mode_o    = state_q;
    assign carry_day = carry_q;

endmodule

// File: tb/tb_relogio_ajustavel.sv
// Directed bench for relogio_ajustavel: a 24 h and a 12 h instance share the
// same inputs; expectations go into a queue drained by a negedge monitor.
module tb_relogio_ajustavel;

    localparam int W = 46;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    localparam logic [W-1:0] MK_H     = {14'h3FFF, 32'h0};
    localparam logic [W-1:0] MK_M     = {14'h0, 14'h3FFF, 18'h0};
    localparam logic [W-1:0] MK_PM    = 46'h8;
    localparam logic [W-1:0] MK_MODE  = 46'h6;
    localparam logic [W-1:0] MK_ALL   = {W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    logic [6:0] a_s_lsd, a_s_msd, a_m_lsd, a_m_msd, a_h_lsd, a_h_msd;
    logic [6:0] b_s_lsd, b_s_msd, b_m_lsd, b_m_msd, b_h_lsd, b_h_msd;
    logic       a_pm, b_pm, a_carry, b_carry;
    logic [1:0] a_mode, b_mode;
    logic [W-1:0] obs24, obs12;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    bit           sel_q[$];

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int st = 0;

    always #5 clk = ~clk;

    relogio_ajustavel #(.TICK_DIV(4), .MODE_12H(0), .SEG_ACTIVE_LOW(1)) dut24 (
        .main_clock (clk),     .main_reset (rst),
        .btn_mode   (btn_mode), .btn_inc   (btn_inc),
        .s_lsd (a_s_lsd), .s_msd (a_s_msd), .m_lsd (a_m_lsd), .m_msd (a_m_msd),
        .h_lsd (a_h_lsd), .h_msd (a_h_msd), .pm (a_pm), .mode_o (a_mode),
        .carry_day (a_carry)
    );

    relogio_ajustavel #(.TICK_DIV(4), .MODE_12H(1), .SEG_ACTIVE_LOW(1)) dut12 (
        .main_clock (clk),     .main_reset (rst),
        .btn_mode   (btn_mode), .btn_inc   (btn_inc),
        .s_lsd (b_s_lsd), .s_msd (b_s_msd), .m_lsd (b_m_lsd), .m_msd (b_m_msd),
        .h_lsd (b_h_lsd), .h_msd (b_h_msd), .pm (b_pm), .mode_o (b_mode),
        .carry_day (b_carry)
    );

    assign obs24 = {a_h_msd, a_h_lsd, a_m_msd, a_m_lsd, a_s_msd, a_s_lsd, a_pm, a_mode, a_carry};
    assign obs12 = {b_h_msd, b_h_lsd, b_m_msd, b_m_lsd, b_s_msd, b_s_lsd, b_pm, b_mode, b_carry};

    function automatic logic [W-1:0] mk(
        input logic [6:0] hm, input logic [6:0] hl, input logic [6:0] mm,
        input logic [6:0] ml, input logic [6:0] sm, input logic [6:0] sl,
        input logic p, input logic [1:0] md, input logic c
    );
        return {hm, hl, mm, ml, sm, sl, p, md, c};
    endfunction

    // Scoreboard monitor: every pending expectation is checked at the negedge.
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] a;
        string        n;
        bit           s;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            n = name_q.pop_front();
            s = sel_q.pop_front();
            a = s ? obs12 : obs24;
            checks++;
            if ((a & m) !== (e & m)) begin
                errors++;
                $display("FAIL %s: got %h expected %h (mask %h)", n, a & m, e & m, m);
            end
        end
    end

    task automatic expect_obs(input string name, input bit sel,
                              input logic [W-1:0] val, input logic [W-1:0] mask);
        exp_q.push_back(val);
        mask_q.push_back(mask);
        name_q.push_back(name);
        sel_q.push_back(sel);
    endtask

    // Advance one clock; ph tracks the prescaler phase, st the editor state.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst) begin
            ph = 0;
            st = 0;
        end else begin
            if (btn_mode && st == 2) ph = 0;
            else ph = (ph + 1) % 4;
            if (btn_mode) st = (st == 2) ? 0 : st + 1;
        end
    endtask

    task automatic pulse(input bit m, input bit i);
        btn_mode = m;
        btn_inc  = i;
        cyc();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc();
    endtask

    task automatic wait_vis(input bit want_vis);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((((ph == 3) || (ph == 0)) != want_vis) && (n < 8));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        repeat (3) cyc();
        expect_obs("reset_init", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);
        expect_obs("reset_init_12h", 1'b1, mk(SB, S2, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);
        rst = 1'b0;

        repeat (9) cyc();
        expect_obs("run_2s", 1'b0, mk(S0, S0, S0, S0, S0, S2, 1'b0, 2'd0, 1'b0), MK_ALL);

        pulse(1'b1, 1'b0);
        expect_obs("enter_set_h", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd1, 1'b0), MK_MODE);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);

        rst = 1'b1;
        expect_obs("reset_mid_edit", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);
        expect_obs("reset_mid_edit_12h", 1'b1, mk(SB, S2, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);
        repeat (2) cyc();
        rst = 1'b0;

        pulse(1'b1, 1'b0);
        repeat (24) pulse(1'b0, 1'b1);
        wait_vis(1'b1);
        expect_obs("set_h_wrap", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd1, 1'b0), MK_H | MK_M | MK_MODE);
        wait_vis(1'b0);
        expect_obs("set_h_blank", 1'b0, mk(SB, SB, S0, S0, S0, S0, 1'b0, 2'd1, 1'b0), MK_H | MK_M);

        repeat (23) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        expect_obs("set_m_entry", 1'b0, mk(S2, S3, S0, S0, S0, S0, 1'b0, 2'd2, 1'b0), MK_H | MK_MODE);
        repeat (60) pulse(1'b0, 1'b1);
        wait_vis(1'b1);
        expect_obs("set_m_wrap", 1'b0, mk(S2, S3, S0, S0, S0, S0, 1'b0, 2'd2, 1'b0), MK_H | MK_M);
        repeat (59) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);

        repeat (236) cyc();
        expect_obs("at_235959", 1'b0, mk(S2, S3, S5, S9, S5, S9, 1'b0, 2'd0, 1'b0), MK_ALL);
        expect_obs("at_235959_12h", 1'b1, mk(S1, S1, S5, S9, S5, S9, 1'b1, 2'd0, 1'b0), MK_ALL);
        repeat (3) cyc();
        expect_obs("carry_day", 1'b0, mk(S2, S3, S5, S9, S5, S9, 1'b0, 2'd0, 1'b1), MK_ALL);
        cyc();
        expect_obs("rollover", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);
        expect_obs("rollover_12h", 1'b1, mk(S1, S2, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);

        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        expect_obs("collision", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd2, 1'b0), MK_H | MK_MODE);

        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        expect_obs("run_inc_ignored", 1'b0, mk(S0, S0, S0, S0, S0, S0, 1'b0, 2'd0, 1'b0), MK_ALL);

        pulse(1'b1, 1'b0);
        repeat (13) pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        expect_obs("hour13", 1'b0, mk(S1, S3, S0, S0, S0, S0, 1'b0, 2'd2, 1'b0), MK_H | MK_MODE | MK_PM);
        expect_obs("hour13_12h", 1'b1, mk(SB, S1, S0, S0, S0, S0, 1'b1, 2'd2, 1'b0), MK_H | MK_MODE | MK_PM);

        repeat (2) cyc();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
